// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, helpers.
// Ops 100/101 are legal only when MDU_MADD_EN is defined.
package mdu_pkg;

    localparam int MDU_WIDTH      = 32;
    localparam int MDU_ITERATIONS = MDU_WIDTH;
    localparam logic [MDU_WIDTH-1:0] DIV0_LO = '1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } mdu_state_e;

    function automatic logic op_legal(input logic [2:0] o);
        case (o)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_legal = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB:                   op_legal = 1'b1;
`endif
            default:                            op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_div(input logic [2:0] o);
        op_is_div = (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] o);
        op_is_signed = (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Two's-complement conditional negate; with neg_i = sign bit it yields the magnitude.
module mdu_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MADD/MSUB accumulate when
// MDU_MADD_EN is defined.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output mdu_state_e       dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    // Handshake: start is taken only while busy=0 with a legal op; the result is
    // on hi/lo when done pulses, and a new start may be issued in that same cycle.
    mdu_state_e       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic             neg_p_q, neg_p_d;
    logic             neg_r_q, neg_r_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             sgn_in;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign sgn_in = op_is_signed(op);

    mdu_abs_neg #(.W(WIDTH)) u_abs_rs (
        .val_i(rs_data), .neg_i(sgn_in & rs_data[WIDTH-1]), .res_o(rs_mag));
    mdu_abs_neg #(.W(WIDTH)) u_abs_rt (
        .val_i(rt_data), .neg_i(sgn_in & rt_data[WIDTH-1]), .res_o(rt_mag));
    mdu_abs_neg #(.W(W2)) u_fix_prod (
        .val_i(acc_q), .neg_i(neg_p_q), .res_o(prod_fix));
    mdu_abs_neg #(.W(WIDTH)) u_fix_quo (
        .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_p_q), .res_o(quo_fix));
    mdu_abs_neg #(.W(WIDTH)) u_fix_rem (
        .val_i(acc_q[W2-1:WIDTH]), .neg_i(neg_r_q), .res_o(rem_fix));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    logic [WIDTH:0]  add_sum;
    logic [W2-1:0]   mul_next;
    assign add_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mcand_q};
    assign mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[W2-1:WIDTH], acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left.
    logic [WIDTH:0]   rem_sh;
    logic             borrow;
    logic [WIDTH-1:0] diff_lo;
    logic [W2-1:0]    div_next;
    assign rem_sh   = acc_q[W2-1:WIDTH-1];
    assign borrow   = rem_sh < {1'b0, mcand_q};
    assign diff_lo  = rem_sh[WIDTH-1:0] - mcand_q;
    assign div_next = {(borrow ? rem_sh[WIDTH-1:0] : diff_lo), acc_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start && op_legal(op)) begin
                    op_d    = op;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    neg_p_d = sgn_in & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    neg_r_d = sgn_in & rs_data[WIDTH-1];
                    state_d = RUN;
                    if (op_is_div(op)) begin
                        mcand_d = rt_mag;
                        acc_d   = {{WIDTH{1'b0}}, rs_mag};
                        if (rt_data == '0) begin
                            // Preload the divide-by-zero answer so FIXUP writes it unchanged.
                            acc_d   = {rs_data, WIDTH'(DIV0_LO)};
                            neg_p_d = 1'b0;
                            neg_r_d = 1'b0;
                            dz_d    = 1'b1;
                            state_d = FIXUP;
                        end
                    end else begin
                        mcand_d = rs_mag;
                        acc_d   = {{WIDTH{1'b0}}, rt_mag};
                    end
                end else begin
                    if (hi_we) hi_d = wr_data;
                    if (lo_we) lo_d = wr_data;
                end
            end
            RUN: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIXUP;
            end
            FIXUP: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (op_is_div(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
`ifdef MDU_MADD_EN
                    if (op_q == OP_MADD)      {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
                    else if (op_q == OP_MSUB) {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
                    else                      {hi_d, lo_d} = prod_fix;
`else
                    {hi_d, lo_d} = prod_fix;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// scored against a plain-arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W  = 32;
    localparam int EW = 2*W + 1 + 32;

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [2:0]   op;
    logic [W-1:0] rs_data, rt_data, wr_data;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;
    mdu_state_e   dbg_state;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [EW-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // reference model: returns {div_by_zero, hi, lo}
    function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] chi,
                                           input logic [W-1:0] clo);
        longint sp;
        int     sq, sr;
        logic [63:0] up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(a) * 64'(b);
        model = {1'b0, chi, clo};
        case (o)
            OP_MULT:  model = {1'b0, 64'(sp)};
            OP_MULTU: model = {1'b0, up};
            OP_DIV: begin
                if (b == 0) model = {1'b1, a, {W{1'b1}}};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {1'b0, 32'h0, 32'h8000_0000};
                else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    model = {1'b0, 32'(sr), 32'(sq)};
                end
            end
            OP_DIVU: begin
                if (b == 0) model = {1'b1, a, {W{1'b1}}};
                else        model = {1'b0, a % b, a / b};
            end
`ifdef MDU_MADD_EN
            OP_MADD: model = {1'b0, {chi, clo} + 64'(sp)};
            OP_MSUB: model = {1'b0, {chi, clo} - 64'(sp)};
`endif
            default: model = {1'b0, chi, clo};
        endcase
    endfunction

    // driver tasks (called and returning on negedges)
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_checks++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W:0] r;
        int unsigned  lat;
        wait_idle();
        r   = model(o, a, b, m_hi, m_lo);
        lat = ((o == OP_DIV || o == OP_DIVU) && b == 0) ? 1 : W + 1;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        exp_q.push_back({r, 32'(cyc + 1 + lat)});
        m_hi = r[2*W-1:W];
        m_lo = r[W-1:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic mt(input logic whi, input logic wlo, input logic [W-1:0] d);
        wait_idle();
        hi_we = whi; lo_we = wlo; wr_data = d;
        if (whi) m_hi = d;
        if (wlo) m_lo = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       pick = '0;
            1:       pick = 32'd1;
            2:       pick = 32'hFFFF_FFFF;
            3:       pick = 32'h8000_0000;
            4:       pick = 32'($urandom_range(0, 15));
            default: pick = $urandom;
        endcase
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_done: done=1 with no operation outstanding");
            end else begin
                e = exp_q.pop_front();
                chk("result_hi",   64'(hi),          64'(e[95:64]));
                chk("result_lo",   64'(lo),          64'(e[63:32]));
                chk("div_by_zero", 64'(div_by_zero), 64'(e[96]));
                chk("done_cycle",  64'(cyc),         64'(e[31:0]));
                chk("busy_in_done", 64'(busy),       64'(0));
            end
        end
    end

    initial begin
        int n;
        logic [2:0] o;
        reset = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(busy), 0);
        chk("rst_done",  64'(done), 0);
        chk("rst_dz",    64'(div_by_zero), 0);
        chk("rst_hi",    64'(hi), 0);
        chk("rst_lo",    64'(lo), 0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        reset = 1'b0;
        @(negedge clk);

        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mult_busy_cycles", 64'(n), 64'd33);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h1);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'h0);

        issue(OP_DIVU, 32'd100, 32'd0);
        wait_idle();
        chk("div0_flag", 64'(div_by_zero), 1);
        chk("div0_hi",   64'(hi), 64'd100);
        chk("div0_lo",   64'(lo), 64'hFFFF_FFFF);

        issue(OP_MULTU, 32'd3, 32'd5);
        wait_idle();
        chk("dz_cleared", 64'(div_by_zero), 0);

        mt(1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("mthi", 64'(hi), 64'hDEAD_BEEF);
        mt(1'b0, 1'b1, 32'h0BAD_F00D);
        chk("mtlo", 64'(lo), 64'h0BAD_F00D);

        // illegal ops are ignored
        for (int k = 0; k < 3; k++) begin
            wait_idle();
            o = (k == 0) ? 3'b110 : (k == 1) ? 3'b111 : OP_MADD;
`ifdef MDU_MADD_EN
            if (k == 2) o = 3'b111;
`endif
            start = 1'b1; op = o;
            @(negedge clk);
            start = 1'b0;
            chk("illegal_op_busy", 64'(busy), 0);
        end

        // start and MTHI while busy are both ignored
        issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge clk);
        start = 1'b1; op = OP_DIVU; rt_data = '0; hi_we = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        wait_idle();
        chk("busy_ignore_hi", 64'(hi), 64'(m_hi));

        // start wins over a simultaneous MTHI
        hi_we = 1'b1; wr_data = 32'h5555_5555;
        issue(OP_MULTU, 32'd2, 32'd3);
        hi_we = 1'b0;
        wait_idle();
        chk("start_wins_hi", 64'(hi), 64'h0);

        // reset mid-RUN abandons the operation
        issue(OP_MULTU, 32'hCAFE_0001, 32'h0000_FFFF);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_hi",   64'(hi), 0);
        chk("midrst_lo",   64'(lo), 0);
        chk("midrst_done", 64'(done), 0);
        exp_q.delete();
        m_hi = '0; m_lo = '0;
        repeat (40) @(negedge clk);

`ifdef MDU_MADD_EN
        mt(1'b1, 1'b0, 32'd0);
        mt(1'b0, 1'b1, 32'd5);
        issue(OP_MADD, 32'd3, 32'd4);
        wait_idle();
        chk("madd_hi", 64'(hi), 64'h0);
        chk("madd_lo", 64'(lo), 64'd17);
        issue(OP_MSUB, 32'd1, 32'd18);
        wait_idle();
        chk("msub_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("msub_lo", 64'(lo), 64'hFFFF_FFFF);
`endif

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                mt(1'($urandom), 1'($urandom), $urandom);
            end else begin
`ifdef MDU_MADD_EN
                o = 3'($urandom_range(0, 5));
`else
                o = 3'($urandom_range(0, 3));
`endif
                issue(o, pick(), pick());
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("final_hi", 64'(hi), 64'(m_hi));
        chk("final_lo", 64'(lo), 64'(m_lo));
        chk("queue_empty", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
